// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, reserve port, tagged write ports,
// flush and status outputs. The master side is the pipeline; the slave side
// is the register file.
interface regfile_sb_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 2,
  parameter int unsigned TAGW   = 3
);
  localparam int unsigned RW = $clog2(NREGS);

  logic [NREAD*RW-1:0]     rs_addr;
  logic [NREAD*XLEN-1:0]   rs_data;
  logic [NREAD-1:0]        rs_valid;
  logic                    rsv_en;
  logic [RW-1:0]           rsv_reg;
  logic [TAGW-1:0]         rsv_tag;
  logic [NWRITE-1:0]       wen;
  logic [NWRITE*RW-1:0]    wreg;
  logic [NWRITE*TAGW-1:0]  wtag;
  logic [NWRITE*XLEN-1:0]  wdata;
  logic                    flush;
  logic                    pending;
  logic [15:0]             stale_cnt;

  modport master (
    output rs_addr, rsv_en, rsv_reg, rsv_tag, wen, wreg, wtag, wdata, flush,
    input  rs_data, rs_valid, pending, stale_cnt
  );

  modport slave (
    input  rs_addr, rsv_en, rsv_reg, rsv_tag, wen, wreg, wtag, wdata, flush,
    output rs_data, rs_valid, pending, stale_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Scoreboarded register file: NREGS x XLEN with x0 hardwired to zero,
// NREAD combinational read ports with same-cycle write bypass, NWRITE
// tagged write ports. A write commits only if its tag matches the tag of
// the outstanding reservation; otherwise it is dropped and counted as stale.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 2,
  parameter int unsigned TAGW   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  regfile_sb_if.slave bus
);
  localparam int unsigned RW = $clog2(NREGS);

  logic [XLEN-1:0]   data_q  [NREGS];
  logic [XLEN-1:0]   data_d  [NREGS];
  logic [NREGS-1:0]  valid_q, valid_d;
  logic [TAGW-1:0]   ptag_q  [NREGS];
  logic [TAGW-1:0]   ptag_d  [NREGS];
  logic [15:0]       stale_cnt_q, stale_cnt_d;

  logic [RW-1:0]     wreg_a  [NWRITE];
  logic [TAGW-1:0]   wtag_a  [NWRITE];
  logic [XLEN-1:0]   wdata_a [NWRITE];
  logic [RW-1:0]     raddr_a [NREAD];

  logic [NWRITE-1:0] commit;
  logic [NWRITE-1:0] stale;
  logic [NREGS-1:0]  cmt_hit;
  logic [XLEN-1:0]   cmt_data [NREGS];
  logic [16:0]       stale_sum;

  // Unpack the flat port buses into per-port fields
  always_comb begin
    for (int unsigned p = 0; p < NWRITE; p++) begin
      wreg_a[p]  = bus.wreg[p*RW +: RW];
      wtag_a[p]  = bus.wtag[p*TAGW +: TAGW];
      wdata_a[p] = bus.wdata[p*XLEN +: XLEN];
    end
    for (int unsigned k = 0; k < NREAD; k++) begin
      raddr_a[k] = bus.rs_addr[k*RW +: RW];
    end
  end

  // Classify each write port as commit or stale against registered state
  always_comb begin
    commit = '0;
    stale  = '0;
    for (int unsigned p = 0; p < NWRITE; p++) begin
      commit[p] = bus.wen[p] && (wreg_a[p] != '0) && !valid_q[wreg_a[p]] &&
                  (wtag_a[p] == ptag_q[wreg_a[p]]);
      stale[p]  = bus.wen[p] && (wreg_a[p] != '0) && !commit[p];
    end
  end

  // Resolve the winning commit per register; later ports override earlier
  always_comb begin
    cmt_hit = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      cmt_data[i] = '0;
    end
    for (int unsigned p = 0; p < NWRITE; p++) begin
      if (commit[p]) begin
        cmt_hit[wreg_a[p]]  = 1'b1;
        cmt_data[wreg_a[p]] = wdata_a[p];
      end
    end
  end

  // Next state: commit, then reserve overrides valid/ptag, then flush
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ptag_d  = ptag_q;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (cmt_hit[i]) begin
        data_d[i]  = cmt_data[i];
        valid_d[i] = 1'b1;
      end
    end
    if (bus.rsv_en && (bus.rsv_reg != '0) && !bus.flush) begin
      valid_d[bus.rsv_reg] = 1'b0;
      ptag_d[bus.rsv_reg]  = bus.rsv_tag;
    end
    if (bus.flush) begin
      valid_d = '1;
    end
    data_d[0]  = '0;
    valid_d[0] = 1'b1;
    ptag_d[0]  = '0;
  end

  // Saturating stale-write counter
  always_comb begin
    stale_sum = {1'b0, stale_cnt_q};
    for (int unsigned p = 0; p < NWRITE; p++) begin
      stale_sum = stale_sum + 17'(stale[p]);
    end
    stale_cnt_d = stale_sum[16] ? 16'hFFFF : stale_sum[15:0];
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        data_q[i] <= '0;
        ptag_q[i] <= '0;
      end
      valid_q     <= '1;
      stale_cnt_q <= '0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      ptag_q      <= ptag_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  // Combinational read ports with bypass; forced to reset values in reset
  always_comb begin
    bus.rs_data  = '0;
    bus.rs_valid = '1;
    for (int unsigned k = 0; k < NREAD; k++) begin
      if (reset_n && (raddr_a[k] != '0)) begin
        if (cmt_hit[raddr_a[k]]) begin
          bus.rs_data[k*XLEN +: XLEN] = cmt_data[raddr_a[k]];
          bus.rs_valid[k]             = 1'b1;
        end else begin
          bus.rs_data[k*XLEN +: XLEN] = data_q[raddr_a[k]];
          bus.rs_valid[k]             = valid_q[raddr_a[k]];
        end
      end
    end
  end

  // Status outputs from registered state
  always_comb begin
    bus.pending   = reset_n && (valid_q != '1);
    bus.stale_cnt = reset_n ? stale_cnt_q : '0;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random
// traffic, compared against a behavioural array model of the register file.
module tb_regfile_sb;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned NREAD  = 2;
  localparam int unsigned NWRITE = 2;
  localparam int unsigned TAGW   = 3;
  localparam int unsigned RW     = 5;

  logic clk = 1'b0;
  logic reset_n;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .TAGW(TAGW)) bus();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .TAGW(TAGW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] mdata [NREGS];
  bit          mvalid[NREGS];
  int unsigned mtag  [NREGS];
  int unsigned mstale;

  // Per-cycle stimulus
  int unsigned ra[NREAD];
  bit          rsv;
  int unsigned rreg, rtag;
  bit          we[NWRITE];
  int unsigned wr[NWRITE], wt[NWRITE];
  logic [31:0] wd[NWRITE];
  bit          fl;
  bit          rst;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mdata[i] = '0; mvalid[i] = 1'b1; mtag[i] = 0;
    end
    mstale = 0;
  endtask

  task automatic idle();
    for (int k = 0; k < NREAD; k++) ra[k] = 0;
    rsv = 0; rreg = 0; rtag = 0;
    for (int p = 0; p < NWRITE; p++) begin
      we[p] = 0; wr[p] = 0; wt[p] = 0; wd[p] = '0;
    end
    fl = 0; rst = 0;
  endtask

  // Drive one cycle from the falling edge, check outputs, then advance model
  task automatic step();
    bit          cm[NWRITE];
    logic [31:0] exp_d;
    bit          exp_v;
    bit          exp_pend;
    reset_n = !rst;
    for (int k = 0; k < NREAD; k++) bus.rs_addr[k*RW +: RW] = RW'(ra[k]);
    bus.rsv_en  = rsv;
    bus.rsv_reg = RW'(rreg);
    bus.rsv_tag = TAGW'(rtag);
    for (int p = 0; p < NWRITE; p++) begin
      bus.wen[p]                 = we[p];
      bus.wreg[p*RW +: RW]       = RW'(wr[p]);
      bus.wtag[p*TAGW +: TAGW]   = TAGW'(wt[p]);
      bus.wdata[p*XLEN +: XLEN]  = wd[p];
    end
    bus.flush = fl;
    #1;
    for (int p = 0; p < NWRITE; p++)
      cm[p] = !rst && we[p] && (wr[p] != 0) && !mvalid[wr[p]] && (wt[p] == mtag[wr[p]]);
    for (int k = 0; k < NREAD; k++) begin
      exp_d = '0; exp_v = 1'b1;
      if (!rst && ra[k] != 0) begin
        exp_d = mdata[ra[k]]; exp_v = mvalid[ra[k]];
        for (int p = 0; p < NWRITE; p++)
          if (cm[p] && wr[p] == ra[k]) begin exp_d = wd[p]; exp_v = 1'b1; end
      end
      check($sformatf("rd%0d_data x%0d", k, ra[k]), 64'(bus.rs_data[k*XLEN +: XLEN]), 64'(exp_d));
      check($sformatf("rd%0d_valid x%0d", k, ra[k]), 64'(bus.rs_valid[k]), 64'(exp_v));
    end
    exp_pend = 1'b0;
    if (!rst) for (int i = 1; i < NREGS; i++) if (!mvalid[i]) exp_pend = 1'b1;
    check("pending", 64'(bus.pending), 64'(exp_pend));
    check("stale_cnt", 64'(bus.stale_cnt), rst ? 64'd0 : 64'(mstale));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (cm[p]) begin mdata[wr[p]] = wd[p]; mvalid[wr[p]] = 1'b1; end
        else if (we[p] && wr[p] != 0) mstale = (mstale >= 65535) ? 65535 : mstale + 1;
      end
      if (rsv && rreg != 0 && !fl) begin mvalid[rreg] = 1'b0; mtag[rreg] = rtag; end
      if (fl) for (int i = 0; i < NREGS; i++) mvalid[i] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic wr_port(input int p, input int unsigned r, input int unsigned t, input logic [31:0] d);
    we[p] = 1; wr[p] = r; wt[p] = t; wd[p] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    idle(); rst = 1;
    @(negedge clk);
    step(); step();

    // Reserve / read-invalid / bypass / read from state
    idle(); rsv = 1; rreg = 5; rtag = 3; step();
    idle(); ra[0] = 5; step();
    idle(); ra[0] = 5; wr_port(0, 5, 3, 32'hDEADBEEF); step();
    idle(); ra[0] = 5; step();

    // Re-reserve makes the older producer stale
    idle(); rsv = 1; rreg = 7; rtag = 1; step();
    idle(); rsv = 1; rreg = 7; rtag = 2; step();
    idle(); ra[0] = 7; wr_port(0, 7, 1, 32'h11); step();
    idle(); ra[0] = 7; wr_port(1, 7, 2, 32'h22); step();
    idle(); ra[0] = 7; step();

    // Dual commit to one register, highest port wins; x0 writes ignored
    idle(); rsv = 1; rreg = 9; rtag = 4; step();
    idle(); ra[0] = 9; wr_port(0, 9, 4, 32'hA); wr_port(1, 9, 4, 32'hB); step();
    idle(); ra[0] = 9; ra[1] = 0; wr_port(0, 0, 0, 32'hFFFFFFFF); step();
    idle(); ra[1] = 0; step();

    // Commit and re-reserve in one cycle
    idle(); rsv = 1; rreg = 3; rtag = 0; step();
    idle(); ra[0] = 3; wr_port(0, 3, 0, 32'h55); rsv = 1; rreg = 3; rtag = 6; step();
    idle(); ra[0] = 3; step();
    idle(); ra[0] = 3; wr_port(1, 3, 6, 32'h66); step();
    idle(); ra[0] = 3; step();

    // Flush outranks a same-cycle reserve; cancelled tags become stale
    idle(); rsv = 1; rreg = 1; rtag = 1; step();
    idle(); rsv = 1; rreg = 2; rtag = 2; step();
    idle(); rsv = 1; rreg = 4; rtag = 4; step();
    idle(); fl = 1; rsv = 1; rreg = 8; rtag = 5; ra[0] = 2; step();
    idle(); ra[0] = 8; ra[1] = 2; step();
    idle(); ra[0] = 2; wr_port(0, 2, 2, 32'h77); step();
    idle(); ra[0] = 2; step();

    // Reset mid-stream with reservations outstanding and stale_cnt at 5
    while (mstale < 5) begin idle(); wr_port(0, 1, 0, 32'h1); step(); end
    idle(); rsv = 1; rreg = 10; rtag = 2; step();
    idle(); rst = 1; ra[0] = 10; ra[1] = 5; rsv = 1; rreg = 11; wr_port(0, 5, 0, 32'h9); step();
    idle(); ra[0] = 10; ra[1] = 5; step();

    // Random traffic on a small register/tag window to force collisions
    for (int n = 0; n < 3000; n++) begin
      idle();
      for (int k = 0; k < NREAD; k++) ra[k] = $urandom_range(0, 7);
      rsv = 1'($urandom_range(0, 1)); rreg = $urandom_range(0, 7); rtag = $urandom_range(0, 3);
      for (int p = 0; p < NWRITE; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        wr[p] = $urandom_range(0, 7);
        wt[p] = ($urandom_range(0, 2) != 0) ? mtag[wr[p]] : $urandom_range(0, 7);
        wd[p] = $urandom;
      end
      fl  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    // Saturation: two stale writes per cycle to a valid register
    idle(); rst = 1; step();
    for (int n = 0; n < 32768; n++) begin
      idle(); ra[0] = $urandom_range(0, 7);
      wr_port(0, 1, 0, $urandom); wr_port(1, 1, 0, $urandom);
      step();
    end
    idle(); wr_port(0, 1, 0, 32'h5); step();
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
